// File: rtl/led_cpu_with_ram_pkg.sv
// Shared definitions for the switch-programmable LED sequencer.
// Holds the sequencer state encoding, RAM geometry and the duration
// value that marks the end of a program (a jump back to address 0).
package led_cpu_with_ram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // A duration byte of this value never displays; it loops pc to 0.
  localparam logic [DATA_W-1:0] TERM_DUR = 8'h00;

  typedef enum logic [2:0] {
    LOAD_MODE = 3'd0,
    FETCH_P   = 3'd1,
    FETCH_D   = 3'd2,
    LOAD      = 3'd3,
    EXEC      = 3'd4
  } state_t;

  // Number of clocks one duration unit lasts; FREQ of 0 or 1 means one clock.
  function automatic int unit_clocks(input int freq);
    return (freq < 2) ? 1 : freq;
  endfunction

endpackage

// File: rtl/led_cpu_with_ram_mem_1r1w.sv
// Program RAM: 2**AW x DW, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives rst.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (combinational read)
//   rdata - read data
module mem_1r1w
  import led_cpu_with_ram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] array [0:(1<<AW)-1];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      array[waddr] <= wdata;
    end
  end

  assign rdata = array[raddr];

endmodule

// File: rtl/led_cpu_with_ram.sv
// Switch-programmable LED sequencer.
// Load mode: each press-and-release of enter stores the switch byte at
// the next RAM address (pattern, duration pairs). A zero duration, or a
// write to the last address, starts execution, which loops forever.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset (RAM contents retained)
//   switch     - byte committed on each enter release
//   enter      - commit button, asynchronous to clk
//   outPattern - registered LED pattern (00 while loading)
module led_cpu_with_ram
  import led_cpu_with_ram_pkg::*;
#(
  parameter int NDELAY = 0,
  parameter int FREQ   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] switch,
  input  logic              enter,
  output logic [DATA_W-1:0] outPattern
);

  localparam int UNIT  = unit_clocks(FREQ);
  localparam int CNT_W = DATA_W + $clog2(UNIT + 1);

  logic enter_meta;
  logic enter_sync;
  logic level;
  logic level_prev;
  logic commit;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_meta <= 1'b0;
      enter_sync <= 1'b0;
    end else begin
      enter_meta <= enter;
      enter_sync <= enter_meta;
    end
  end

  generate
    if (NDELAY == 0) begin : g_nodeb
      assign level = enter_sync;
    end else begin : g_deb
      localparam int DB_W = (NDELAY > 1) ? $clog2(NDELAY) : 1;
      logic [DB_W-1:0] db_cnt;
      logic            db_level;

      // Accept a new level only after it has differed for NDELAY clocks
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          db_cnt   <= '0;
          db_level <= 1'b0;
        end else if (enter_sync == db_level) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(NDELAY - 1)) begin
          db_level <= enter_sync;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      assign level = db_level;
    end
  endgenerate

  // Previous filtered level for release detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign commit = level_prev & ~level;

  state_t              state;
  logic [ADDR_W-1:0]   wp;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   pat;
  logic [DATA_W-1:0]   dur;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_en;

  // FETCH_D looks at the duration byte next to the pattern
  assign rd_addr = (state == FETCH_D) ? (pc + 8'd1) : pc;
  assign wr_en   = (state == LOAD_MODE) && commit;

  mem_1r1w #(.AW(ADDR_W), .DW(DATA_W)) mem1R1W_1 (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wp),
    .wdata (switch),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Loader and run-mode sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_MODE;
      wp         <= 8'd0;
      pc         <= 8'd0;
      pat        <= 8'h00;
      dur        <= 8'h00;
      cnt        <= '0;
      outPattern <= 8'h00;
    end else begin
      case (state)
        LOAD_MODE: begin
          if (commit) begin
            wp <= wp + 8'd1;
            // Zero duration ends the program; the last address also
            // ends loading since there is nowhere left to write.
            if ((wp[0] && (switch == TERM_DUR)) || (wp == 8'hFF)) begin
              pc    <= 8'd0;
              state <= FETCH_P;
            end
          end
        end
        FETCH_P: begin
          pat   <= rd_data;
          state <= FETCH_D;
        end
        FETCH_D: begin
          if (rd_data == TERM_DUR) begin
            pc    <= 8'd0;
            state <= FETCH_P;
          end else begin
            dur   <= rd_data;
            state <= LOAD;
          end
        end
        LOAD: begin
          outPattern <= pat;
          cnt        <= CNT_W'(dur) * CNT_W'(UNIT);
          pc         <= pc + 8'd2;
          state      <= EXEC;
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          // <= guards against a zero count ever stalling the sequencer
          if (cnt <= CNT_W'(1)) begin
            state <= FETCH_P;
          end
        end
        default: begin
          state <= LOAD_MODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_cpu_with_ram.sv
// Self-checking bench for led_cpu_with_ram. Three instances share the
// inputs: default parameters, FREQ=4 and NDELAY=3; each test checks
// only the instance it is aimed at.
module tb_led_cpu_with_ram;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [7:0] switch;
  logic [7:0] out0;
  logic [7:0] outf;
  logic [7:0] outd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         t;
    logic [7:0] exp;
  } samp_t;

  samp_t      basic_samp [12];
  logic [7:0] basic_prog [8];

  led_cpu_with_ram #(.NDELAY(0), .FREQ(0)) dut (
    .clk(clk), .rst(rst), .switch(switch), .enter(enter), .outPattern(out0));
  led_cpu_with_ram #(.NDELAY(0), .FREQ(4)) dut_f (
    .clk(clk), .rst(rst), .switch(switch), .enter(enter), .outPattern(outf));
  led_cpu_with_ram #(.NDELAY(3), .FREQ(0)) dut_d (
    .clk(clk), .rst(rst), .switch(switch), .enter(enter), .outPattern(outd));

  // first posedge at 10, period 10
  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pick(input int w);
    case (w)
      0:       return out0;
      1:       return outf;
      default: return outd;
    endcase
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) at negedges until the selected output equals exp.
  task automatic wait_pat(input int w, input logic [7:0] exp, input int max_clks,
                          input string name, output int n);
    n = 0;
    while (pick(w) !== exp && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pick(w) !== exp) begin
      errors++;
      $display("FAIL %s: timeout, got %02h expected %02h", name, pick(w), exp);
    end
  endtask

  task automatic check_steady(input int w, input logic [7:0] exp, input int nclk,
                              input string name);
    int bad = 0;
    logic [7:0] last_bad = 8'h00;
    repeat (nclk) begin
      @(negedge clk);
      if (pick(w) !== exp) begin
        bad++;
        last_bad = pick(w);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: got %02h on %0d clocks expected %02h", name, last_bad, bad, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic commit(input logic [7:0] b, input int hi, input int lo);
    @(negedge clk);
    enter = 1'b1;
    repeat (hi) @(negedge clk);
    enter  = 1'b0;
    switch = b;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    enter  = 1'b0;
    switch = 8'h00;

    basic_prog = '{8'hAA, 8'h01, 8'h88, 8'h03, 8'hF0, 8'h02, 8'h00, 8'h00};
    basic_samp[0]  = '{35,  8'h00};
    basic_samp[1]  = '{295, 8'h00};
    basic_samp[2]  = '{325, 8'h00};
    basic_samp[3]  = '{335, 8'hAA};
    basic_samp[4]  = '{365, 8'hAA};
    basic_samp[5]  = '{375, 8'h88};
    basic_samp[6]  = '{415, 8'h88};
    basic_samp[7]  = '{435, 8'hF0};
    basic_samp[8]  = '{495, 8'hF0};
    basic_samp[9]  = '{505, 8'hAA};
    basic_samp[10] = '{585, 8'h88};
    basic_samp[11] = '{645, 8'hF0};

    // ---- Basic program on absolute spec timing ----
    fork
      begin
        #40 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
          #2  enter = 1'b1;
          #20 enter = 1'b0;
          switch = basic_prog[k];
          #8;
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          #(basic_samp[i].t - int'($time));
          check8($sformatf("basic_t%0d", basic_samp[i].t), out0, basic_samp[i].exp);
        end
      end
    join
    check8("basic_mem1", dut.mem1R1W_1.array[1], 8'h01);
    check8("basic_mem7", dut.mem1R1W_1.array[7], 8'h00);

    // ---- Immediate terminator: jump loop, LEDs stay dark ----
    do_reset();
    check8("reset_out", out0, 8'h00);
    commit(8'h55, 2, 6);
    commit(8'h00, 2, 6);
    check_steady(0, 8'h00, 30, "imm_term");

    // ---- FREQ=4: single instruction shows constantly ----
    do_reset();
    commit(8'h0F, 2, 6);
    commit(8'h02, 2, 6);
    commit(8'h00, 2, 6);
    commit(8'h00, 2, 6);
    wait_pat(1, 8'h0F, 20, "f4_first", n);
    check_steady(1, 8'h0F, 40, "f4_steady");

    // ---- FREQ=4: two instructions, display times 3+8 and 3+4+2 ----
    do_reset();
    commit(8'h0F, 2, 6);
    commit(8'h02, 2, 6);
    commit(8'hF0, 2, 6);
    commit(8'h01, 2, 6);
    commit(8'h00, 2, 6);
    commit(8'h00, 2, 6);
    wait_pat(1, 8'h0F, 20, "f4b_first", n);
    wait_pat(1, 8'hF0, 40, "f4b_f0", n);
    check_int("f4b_0f_clocks", n, 11);
    wait_pat(1, 8'h0F, 40, "f4b_0f", n);
    check_int("f4b_f0_clocks", n, 9);
    wait_pat(1, 8'hF0, 40, "f4b_f0_again", n);
    check_int("f4b_0f_clocks2", n, 11);

    // ---- NDELAY=3: glitch rejected, long presses commit once ----
    do_reset();
    @(negedge clk);
    switch = 8'hAA;
    enter  = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (8) @(negedge clk);
    commit(8'h3C, 10, 8);
    commit(8'h01, 10, 8);
    commit(8'h00, 10, 8);
    commit(8'h00, 10, 8);
    check8("deb_mem0", dut_d.mem1R1W_1.array[0], 8'h3C);
    check8("deb_mem1", dut_d.mem1R1W_1.array[1], 8'h01);
    wait_pat(2, 8'h3C, 20, "deb_run", n);
    check_steady(2, 8'h3C, 20, "deb_steady");

    // ---- Reset mid-run, then reload ----
    do_reset();
    commit(8'h77, 2, 6);
    commit(8'h0A, 2, 6);
    commit(8'h00, 2, 6);
    commit(8'h00, 2, 6);
    wait_pat(0, 8'h77, 20, "mid_first", n);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check8("mid_async_rst", out0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_steady(0, 8'h00, 5, "mid_load_mode");
    commit(8'h11, 2, 6);
    commit(8'h01, 2, 6);
    commit(8'h00, 2, 6);
    commit(8'h00, 2, 6);
    wait_pat(0, 8'h11, 20, "reload_first", n);
    check_steady(0, 8'h11, 20, "reload_steady");

    // ---- Full memory: run starts after address 255, pc wraps ----
    do_reset();
    for (int a = 0; a < 255; a++) begin
      commit((a % 2 == 1) ? 8'h01 : 8'(a / 2 + 1), 2, 6);
    end
    check8("full_still_loading", out0, 8'h00);
    commit(8'h01, 2, 6);
    check8("full_mem255", dut.mem1R1W_1.array[255], 8'h01);
    wait_pat(0, 8'h01, 20, "full_first", n);
    wait_pat(0, 8'h80, 600, "full_last", n);
    wait_pat(0, 8'h01, 10, "full_wrap", n);
    check_int("full_wrap_clocks", n, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
